rot_imm_arbiter: RTL and testbench
==================================

Name: rot_imm_arbiter

Overview:
- Shares one combinational 8-bit immediate rotator between NREQ requesters (decode stage, message-decode unit, ...).
- Round-robin grant, valid/ready handshake on every port.
- Single registered result stage carrying the requester ID; one-cycle latency; one result per cycle when not backpressured.
- Sits between the instruction/message decode front-end and the ALU operand path.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (minimum 1), width of the requester ID tag.
- CNTW, 16, width of the saturating stall counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_imm  in  NREQ*8  8-bit immediate per requester; requester i uses bits [8i+7:8i].
- req_rot  in  NREQ*4  4-bit rotate amount per requester; requester i uses bits [4i+3:4i].
- req_ready  out  NREQ  one-hot-or-zero grant/accept.
- res_valid  out  1  result register holds a valid result.
- res_data  out  32  rotated immediate, zero-extended.
- res_id  out  IDW  index of the requester that produced res_data.
- res_ready  in  1  consumer accepts the result.
- stall_cnt  out  CNTW  count of cycles with res_valid=1 and res_ready=0; saturating.

Behaviour:
- Reset (asynchronous, immediate):
  - res_valid=0, res_data=0, res_id=0, stall_cnt=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
- Rotation function: res_data = {24'b0, ror8(imm, rot mod 8)}.
  - ror8 rotates the 8-bit value right within 8 bits.
  - rot 8..15 gives the same result as rot 0..7.
  - Upper 24 bits are always 0.
- Advance condition: adv = !res_valid || res_ready. Both terms use registered state plus res_ready.
- Grant:
  - Pick the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - req_ready[i] = adv && granted[i].
  - req_ready is combinational from req_valid, ptr and res_ready.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i] at the clock edge.
  - On transfer: res_data <= ror(req_imm[i], req_rot[i]), res_id <= i, res_valid <= 1, ptr <= (i+1) mod NREQ.
- Latency: data is accepted in cycle t and appears on res_* in cycle t+1.
- Output drain: if adv=1 and no request is valid, res_valid <= 0. res_data and res_id hold their last values.
- Backpressure:
  - While res_valid=1 and res_ready=0: res_data and res_id stay stable, all req_ready=0, ptr is unchanged.
  - stall_cnt increments each such cycle and saturates at 2^CNTW-1.
- Simultaneous events: res_ready=1 and a new grant in the same cycle replaces the result. Full throughput, no bubble.
- ptr moves only on a transfer. An idle cycle leaves priority unchanged.
- Requester rule: once req_valid is raised, the requester holds it and the data until req_ready. The arbiter does not check this rule.
- Reset mid-operation: a pending result is discarded. No output is produced for it after reset releases.
- With NREQ requesters continuously valid, each requester is served exactly once per NREQ consecutive transfers.

Decomposition:
- Shared package rot_pkg:
  - constants IMM_W=8, ROT_W=4, DATA_W=32.
  - typedef rot_req_t {logic [7:0] imm; logic [3:0] rot;}.
- Sub-module: the existing BarrelShifterALU (A[7:0], Rot[3:0] -> out[31:0]), instantiated once on the muxed granted request.
- Optional internal function rr_pick(valid, ptr) returning the grant index and a found flag. No separate module for it.

Test Plan:
1. Only req0 valid, imm=0xF1, rot=1, res_ready=1 -> req_ready=01 in the same cycle; next cycle res_valid=1, res_data=0x000000F8, res_id=0.
2. req0 (0xF1, rot 4) and req1 (0xF1, rot 13) held valid, res_ready=1 -> grants alternate 0,1,0,1 with no bubbles; results alternate 0x1F (id 0) and 0x8F (id 1).
3. Rotation sweep on req1, imm=0xF1, rot 0,5,8,15 -> 0xF1, 0x8F, 0xF1, 0xE3; upper 24 bits always 0.
4. Result pending with res_ready=0 for 3 cycles while req0 stays valid -> res_data/res_id stable, req_ready=00, stall_cnt=3; res_ready=1 -> req0 accepted that cycle.
5. rst pulsed asynchronously while res_valid=1 and ptr=1 -> res_valid, res_data, res_id, stall_cnt go to 0 without a clock edge; after release with both valid, first grant goes to req0.
6. res_valid=1, res_ready=0 held for 70000 cycles -> stall_cnt=0xFFFF, no wrap to 0.

Source files
------------

// File: rtl/rot_pkg.sv
// rot_pkg: shared constants and request type for the immediate-rotator
// arbiter and its shifter.
//   IMM_W  - width of an immediate operand
//   ROT_W  - width of a rotate amount (only the low 3 bits take effect)
//   DATA_W - width of the zero-extended result
package rot_pkg;

  localparam int IMM_W  = 8;
  localparam int ROT_W  = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic [ROT_W-1:0] rot;
  } rot_req_t;

endpackage

// File: rtl/BarrelShifterALU.sv
// BarrelShifterALU: combinational 8-bit rotate-right, zero-extended to 32 bits.
//   A   - 8-bit operand
//   Rot - rotate amount; amounts 8..15 alias 0..7
//   out - {24'b0, A rotated right by Rot mod 8}
module BarrelShifterALU
  import rot_pkg::*;
(
  input  logic [IMM_W-1:0]  A,
  input  logic [ROT_W-1:0]  Rot,
  output logic [DATA_W-1:0] out
);

  // Shifting a doubled copy right leaves the rotated byte in the low half.
  logic [2*IMM_W-1:0] doubled;

  assign doubled = {A, A} >> Rot[2:0];
  assign out     = {{(DATA_W-IMM_W){1'b0}}, doubled[IMM_W-1:0]};

endmodule

// File: rtl/rot_imm_arbiter.sv
// rot_imm_arbiter: round-robin arbiter sharing one immediate rotator between
// NREQ requesters, with a single registered result stage.
//   clk, rst   - clock (rising edge) and asynchronous active-high reset
//   req_valid  - request pending, one bit per requester
//   req_imm    - 8-bit immediate per requester, [8i+7:8i]
//   req_rot    - 4-bit rotate amount per requester, [4i+3:4i]
//   req_ready  - one-hot-or-zero accept, combinational
//   res_valid  - result register holds a valid result
//   res_data   - rotated immediate, zero-extended
//   res_id     - requester index that produced res_data
//   res_ready  - consumer accepts the result
//   stall_cnt  - saturating count of cycles with res_valid && !res_ready
module rot_imm_arbiter
  import rot_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IMM_W-1:0]  req_imm,
  input  logic [NREQ*ROT_W-1:0]  req_rot,
  output logic [NREQ-1:0]        req_ready,
  output logic                   res_valid,
  output logic [DATA_W-1:0]      res_data,
  output logic [IDW-1:0]         res_id,
  input  logic                   res_ready,
  output logic [CNTW-1:0]        stall_cnt
);

  // Returns {found, index}: first valid requester scanning from ptr upward,
  // wrapping modulo NREQ. The loop runs backwards so the closest hit wins.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  logic                res_valid_reg;
  logic [DATA_W-1:0]   res_data_reg;
  logic [IDW-1:0]      res_id_reg;
  logic [CNTW-1:0]     stall_cnt_reg;
  logic [IDW-1:0]      ptr_reg;

  rot_req_t            reqs [NREQ];
  logic [IDW:0]        pick;
  logic                found;
  logic [IDW-1:0]      gidx;
  logic [IDW-1:0]      ptr_next;
  logic                adv;
  logic                xfer;
  rot_req_t            sel_req;
  logic [DATA_W-1:0]   rot_out;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign reqs[gi].imm = req_imm[gi*IMM_W +: IMM_W];
      assign reqs[gi].rot = req_rot[gi*ROT_W +: ROT_W];
      // Gated by rst so nothing is offered while reset is asserted.
      assign req_ready[gi] = !rst && xfer && (gidx == IDW'(gi));
    end
  endgenerate

  assign pick  = rr_pick(req_valid, ptr_reg);
  assign found = pick[IDW];
  assign gidx  = pick[IDW-1:0];

  // The result register can take new data when empty or being drained.
  assign adv  = !res_valid_reg || res_ready;
  assign xfer = adv && found;

  assign ptr_next = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);

  assign sel_req = reqs[gidx];

  BarrelShifterALU u_rot (
    .A   (sel_req.imm),
    .Rot (sel_req.rot),
    .out (rot_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
      stall_cnt_reg <= '0;
      ptr_reg       <= '0;
    end else begin
      if (xfer) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= rot_out;
        res_id_reg    <= gidx;
        ptr_reg       <= ptr_next;
      end else if (adv) begin
        // Drain: data and id keep their last values.
        res_valid_reg <= 1'b0;
      end
      if (res_valid_reg && !res_ready && (stall_cnt_reg != {CNTW{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + CNTW'(1);
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_rot_imm_arbiter.sv
// tb_rot_imm_arbiter: directed and randomized checks of rot_imm_arbiter
// against a transaction-level reference model.
module tb_rot_imm_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*8-1:0]    req_imm;
  logic [NREQ*4-1:0]    req_rot;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [31:0]          res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_ready;
  logic [CNTW-1:0]      stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_id;
  int m_stall;

  rot_imm_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_imm   (req_imm),
    .req_rot   (req_rot),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ror8(input int imm, input int rot);
    int r;
    r = rot % 8;
    return ((imm >> r) | (imm << (8 - r))) & 255;
  endfunction

  function automatic int get_imm(input int i);
    logic [7:0] v;
    v = req_imm[i*8 +: 8];
    return int'(v);
  endfunction

  function automatic int get_rot(input int i);
    logic [3:0] v;
    v = req_rot[i*4 +: 4];
    return int'(v);
  endfunction

  task automatic set_req(input int i, input bit v, input int imm, input int rot);
    req_valid[i]       = v;
    req_imm[i*8 +: 8]  = 8'(imm);
    req_rot[i*4 +: 4]  = 4'(rot);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_stall = 0;
  endtask

  // One clock cycle: inputs are already driven. Checks req_ready before the
  // edge and all result outputs after it. Returns the granted index or -1.
  task automatic step(input bit quiet, output int g);
    int  exp_ready;
    bit  stall_inc;
    bit  can_take;
    #1;
    g = -1;
    can_take = !m_valid || res_ready;
    if (can_take) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? (1 << g) : 0;
    if (!quiet) check("req_ready", 32'(req_ready), 32'(exp_ready));
    stall_inc = m_valid && !res_ready;
    @(posedge clk);
    if (g >= 0) begin
      m_data  = ror8(get_imm(g), get_rot(g));
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NREQ;
    end else if (can_take) begin
      m_valid = 0;
    end
    if (stall_inc && m_stall < (1 << CNTW) - 1) m_stall++;
    #1;
    if (!quiet) begin
      check("res_valid", 32'(res_valid), 32'(m_valid));
      check("res_data", res_data, 32'(m_data));
      check("res_id", 32'(res_id), 32'(m_id));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      $display("cyc t=%0t grant=%0d res_valid=%0b res_data=0x%02h res_id=%0d stall=%0d",
               $time, g, res_valid, res_data, res_id, stall_cnt);
    end
  endtask

  initial begin
    int g, prev;
    int sweep_rot [4];
    int sweep_exp [4];
    sweep_rot = '{0, 5, 8, 15};
    sweep_exp = '{32'hF1, 32'h8F, 32'hF1, 32'hE3};

    // Reset state; requests asserted to confirm req_ready is held low.
    rst = 1'b1; res_ready = 1'b0;
    req_valid = '1; req_imm = '0; req_rot = '0;
    model_reset();
    #2;
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst res_id", 32'(res_id), 32'd0);
    check("rst stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // 1: single requester, one-cycle latency
    res_ready = 1'b1;
    set_req(0, 1, 8'hF1, 1);
    step(0, g);
    check("t1 grant", 32'(g), 32'd0);
    check("t1 data", res_data, 32'h0000_00F8);
    check("t1 id", 32'(res_id), 32'd0);
    set_req(0, 0, 0, 0);
    step(0, g);

    // 2: both held valid, grants alternate without bubbles
    set_req(0, 1, 8'hF1, 4);
    set_req(1, 1, 8'hF1, 13);
    prev = 0;  // ptr is 1 after test 1, so req1 goes first
    for (int n = 0; n < 4; n++) begin
      step(0, g);
      check("t2 alternate", 32'(g), 32'(1 - prev));
      check("t2 data", res_data, (g == 0) ? 32'h1F : 32'h8F);
      check("t2 valid", 32'(res_valid), 32'd1);
      prev = g;
    end
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);

    // 3: rotation sweep on req1
    for (int n = 0; n < 4; n++) begin
      set_req(1, 1, 8'hF1, sweep_rot[n]);
      step(0, g);
      check("t3 sweep", res_data, sweep_exp[n]);
      set_req(1, 0, 0, 0);
    end

    // 4: backpressure for 3 cycles with req0 waiting
    set_req(1, 1, 8'h3C, 2);
    step(0, g);  // result pending (from req1)
    res_ready = 1'b0;
    set_req(1, 0, 0, 0);
    set_req(0, 1, 8'hA5, 3);
    for (int n = 0; n < 3; n++) begin
      step(0, g);
      check("t4 hold data", res_data, 32'(ror8(8'h3C, 2)));
      check("t4 hold id", 32'(res_id), 32'd1);
    end
    check("t4 stall", 32'(stall_cnt), 32'd3);
    res_ready = 1'b1;
    step(0, g);
    check("t4 accept", 32'(g), 32'd0);

    // 5: asynchronous reset with res_valid=1 and ptr=1
    set_req(0, 0, 0, 0);
    #2; rst = 1'b1; #1;
    check("t5 res_valid", 32'(res_valid), 32'd0);
    check("t5 res_data", res_data, 32'd0);
    check("t5 res_id", 32'(res_id), 32'd0);
    check("t5 stall", 32'(stall_cnt), 32'd0);
    model_reset();
    set_req(0, 1, 8'h81, 1);
    set_req(1, 1, 8'h42, 6);
    check("t5 ready in rst", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("t5 no output", 32'(res_valid), 32'd0);
    rst = 1'b0;
    step(0, g);
    check("t5 first grant", 32'(g), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      step(0, g);
      if (g >= 0) set_req(g, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && i != g && $urandom_range(0, 1) == 1)
          set_req(i, 1, $urandom_range(0, 255), $urandom_range(0, 15));
      end
    end

    // 6: stall counter saturation
    res_ready = 1'b1;
    set_req(0, 1, 8'h11, 0);
    set_req(1, 0, 0, 0);
    step(0, g);
    set_req(0, 0, 0, 0);
    res_ready = 1'b0;
    for (int n = 0; n < 70000; n++) step(1, g);
    check("t6 stall sat", 32'(stall_cnt), 32'h0000_FFFF);
    check("t6 still valid", 32'(res_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
